nn_result_streamer: RTL and testbench
=====================================

// Module: nn_result_streamer
// PURPOSE
//  Output stage downstream of the final NN layer. Captures each final-layer output vector
//  (all neuron outputs, packed) on its valid pulse and serialises it onto an AXI4-Stream
//  master, one neuron per beat, with full tready backpressure. A 2-slot ping-pong buffer
//  lets a new vector arrive while the previous one is still streaming.
// PARAMETERS
//  NUM_OUT     10  neurons per vector (numNeuronLayer3)
//  DATA_WIDTH  16  bits per neuron value, two's complement (dataWidth)
//  CNT_WIDTH   16  width of o_frame_count
// PORTS
//  s_axi_aclk     in   1                      clock
//  reset          in   1                      synchronous, active-high
//  i_valid        in   1                      1-cycle pulse, i_data holds a complete vector
//  i_data         in   NUM_OUT*DATA_WIDTH     neuron k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//  m_axis_tdata   out  DATA_WIDTH             current beat
//  m_axis_tvalid  out  1                      beat valid
//  m_axis_tready  in   1                      sink ready
//  m_axis_tlast   out  1                      last beat of a frame
//  o_overflow     out  1                      sticky: a vector was dropped
//  o_busy         out  1                      any slot full or streaming in progress
//  o_frame_count  out  CNT_WIDTH              frames fully sent, wraps at 2^CNT_WIDTH
// BEHAVIOUR
//  - Reset: all outputs 0, both slots empty, wr_ptr = rd_ptr = 0, beat = 0, state IDLE.
//    Reset mid-frame abandons the frame: no tlast, no count increment, buffered data lost.
//  - Capture: on an edge where i_valid = 1 and slot[wr_ptr] is empty, store i_data there,
//    mark it full and toggle wr_ptr. If both slots are full, drop the vector, set o_overflow
//    (cleared only by reset), and leave both slots and pointers unchanged.
//  - Slot freeing takes priority: a capture on the same edge as the final handshake that
//    frees a slot is accepted, even if both slots were full before that edge.
//  - FSM IDLE: tvalid = 0. Go to SEND when slot[rd_ptr] is full. A vector captured at edge
//    N while IDLE has tvalid = 1 with beat 0 after edge N+1 (1 cycle of latency).
//  - FSM SEND: tvalid = 1, tdata = neuron[beat] of slot[rd_ptr]. Beats go LSB-first: beat 0
//    is neuron 0. beat advances only on tvalid & tready. tdata, tlast and tvalid hold steady
//    while tready = 0.
//  - tlast = 1 only on the final beat: beat NUM_OUT-1, or the argmax beat when ARGMAX_EN is set.
//  - Final handshake: free slot[rd_ptr], toggle rd_ptr, set beat = 0 and increment
//    o_frame_count. If the other slot is full, stay in SEND and present its beat 0 in the
//    next cycle with no bubble. Otherwise go to IDLE.
//  - o_busy = (state == SEND) | slot0_full | slot1_full.
//  - Every beat width is exactly DATA_WIDTH. No arithmetic is done on data except the
//    ARGMAX_EN comparison.
// CONFIGURATION
//  ARGMAX_EN defined:
//  - One extra beat follows the NUM_OUT data beats. It carries the index of the maximum
//    signed neuron value in that frame, zero-extended to DATA_WIDTH.
//  - Ties resolve to the lowest index. tlast moves to this beat; a frame is NUM_OUT+1 beats.
//  - The index is computed at capture time (combinational compare tree, registered with the
//    slot), so the extra beat has no added latency.
//  ARGMAX_EN undefined:
//  - Frames are exactly NUM_OUT beats and no compare logic is synthesised.
// TESTING
//  1. Vector 0..9 (neuron k = k), tready held at 1:
//     -> 10 consecutive beats 0..9, tlast on beat 9, frame_count = 1, o_busy low afterwards.
//  2. Same vector with tready toggling 1,0,0,1,...:
//     -> data and order unchanged, tdata stable during stalls, 10 handshakes, one tlast.
//  3. Three i_valid pulses 1 cycle apart, tready = 0:
//     -> first two vectors buffered, third dropped, o_overflow = 1.
//     Release tready -> exactly 20 beats, no bubble between frames, frame_count = 2.
//  4. Both slots full; the final handshake of frame A and an i_valid pulse land on the same
//     edge -> new vector is accepted, o_overflow stays 0, 3 frames are streamed in total.
//  5. Reset asserted at beat 4 of a frame
//     -> next cycle tvalid = 0, o_busy = 0, frame_count = 0. A new vector after reset
//        streams from beat 0.
//  6. ARGMAX_EN, vector {-5,3,7,7,-1,0,2,1,-8,6} -> 11 beats; beat 10 = 2 with tlast;
//     all-negative vector {-1,...,-1} -> beat 10 = 0.

Source files
------------

// File: rtl/nn_result_streamer.sv
// nn_result_streamer
// Output stage behind the final NN layer.
// - Captures a packed vector of neuron outputs on each i_valid pulse.
// - Stores it in a 2-slot ping-pong buffer.
// - Streams it out on an AXI4-Stream master, one neuron per beat, neuron 0 first.
// Optional feature: define ARGMAX_EN to append one beat per frame. That beat carries
// the index of the largest signed neuron value, and tlast moves onto it.
module nn_result_streamer #(
    parameter int NUM_OUT    = 10,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          s_axi_aclk,
    input  logic                          reset,
    input  logic                          i_valid,
    input  logic [NUM_OUT*DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          o_overflow,
    output logic                          o_busy,
    output logic [CNT_WIDTH-1:0]          o_frame_count
);

    localparam int BEAT_W = $clog2(NUM_OUT + 1);
`ifdef ARGMAX_EN
    localparam int IDX_W    = $clog2(NUM_OUT);
    localparam int LAST_IDX = NUM_OUT;
`else
    localparam int LAST_IDX = NUM_OUT - 1;
`endif
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LAST_IDX);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]                    state;
    logic [NUM_OUT*DATA_WIDTH-1:0] slot_data [2];
    logic [1:0]                    slot_full;
    logic                          wr_ptr;
    logic                          rd_ptr;
    logic [BEAT_W-1:0]             beat;
    logic [NUM_OUT*DATA_WIDTH-1:0] cur_vec;
    logic                          handshake;
    logic                          final_hs;
    logic                          capture;
    logic                          drop;

    // A capture is allowed into an empty slot.
    // It is also allowed into the slot that the final handshake frees on this same edge.
    assign handshake = (state == ST_SEND) && m_axis_tready;
    assign final_hs  = handshake && (beat == LAST_BEAT);
    assign capture   = i_valid && (!slot_full[wr_ptr] || (final_hs && (rd_ptr == wr_ptr)));
    assign drop      = i_valid && !capture;
    assign cur_vec   = slot_data[rd_ptr];

    assign m_axis_tvalid = (state == ST_SEND);
    assign m_axis_tlast  = (state == ST_SEND) && (beat == LAST_BEAT);
    assign o_busy        = (state == ST_SEND) | slot_full[0] | slot_full[1];

`ifdef ARGMAX_EN
    logic [IDX_W-1:0]             in_idx;
    logic signed [DATA_WIDTH-1:0] in_max;
    logic [IDX_W-1:0]             slot_idx [2];

    // Find the max of the incoming vector. A strict compare means a tie keeps the lower index.
    always_comb begin
        in_idx = '0;
        in_max = i_data[DATA_WIDTH-1:0];
        for (int k = 1; k < NUM_OUT; k++) begin
            if ($signed(i_data[k*DATA_WIDTH +: DATA_WIDTH]) > in_max) begin
                in_max = i_data[k*DATA_WIDTH +: DATA_WIDTH];
                in_idx = IDX_W'(k);
            end
        end
    end

    // Register the argmax index next to its vector.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            slot_idx[0] <= '0;
            slot_idx[1] <= '0;
        end else if (capture) begin
            slot_idx[wr_ptr] <= in_idx;
        end
    end
`endif

    // Select the neuron for the current beat. Drive zero when not streaming.
    always_comb begin
        m_axis_tdata = '0;
        if (state == ST_SEND) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (beat == BEAT_W'(k)) begin
                    m_axis_tdata = cur_vec[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`ifdef ARGMAX_EN
            if (beat == BEAT_W'(NUM_OUT)) begin
                m_axis_tdata = DATA_WIDTH'(slot_idx[rd_ptr]);
            end
`endif
        end
    end

    // Ping-pong slot bookkeeping. A capture into the slot freed this edge must leave it full,
    // so the capture assignment comes last.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            slot_data[0] <= '0;
            slot_data[1] <= '0;
            slot_full    <= 2'b00;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
        end else begin
            if (final_hs) begin
                slot_full[rd_ptr] <= 1'b0;
                rd_ptr            <= ~rd_ptr;
            end
            if (capture) begin
                slot_data[wr_ptr] <= i_data;
                slot_full[wr_ptr] <= 1'b1;
                wr_ptr            <= ~wr_ptr;
            end
        end
    end

    // Streaming FSM and beat counter. Frames run back to back when the other slot is ready.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (slot_full[rd_ptr]) begin
                        state <= ST_SEND;
                    end
                end
                default: begin
                    if (handshake) begin
                        beat <= final_hs ? '0 : beat + 1'b1;
                    end
                    if (final_hs && !slot_full[~rd_ptr]) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Sticky overflow flag and completed-frame counter.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            o_overflow    <= 1'b0;
            o_frame_count <= '0;
        end else begin
            if (drop) begin
                o_overflow <= 1'b1;
            end
            if (final_hs) begin
                o_frame_count <= o_frame_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_nn_result_streamer.sv
// tb_nn_result_streamer
// Directed bench for nn_result_streamer.
// Covers single frames, backpressure, overflow, same-edge free/capture, mid-frame reset,
// and the argmax beat when ARGMAX_EN is defined.
module tb_nn_result_streamer;

    localparam int NUM_OUT = 10;
    localparam int DW      = 16;
    localparam int CW      = 16;
`ifdef ARGMAX_EN
    localparam int FRAME_LEN = NUM_OUT + 1;
`else
    localparam int FRAME_LEN = NUM_OUT;
`endif

    logic                  s_axi_aclk;
    logic                  reset;
    logic                  i_valid;
    logic [NUM_OUT*DW-1:0] i_data;
    logic [DW-1:0]         m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  o_overflow;
    logic                  o_busy;
    logic [CW-1:0]         o_frame_count;

    int checks = 0;
    int errors = 0;

    nn_result_streamer #(.NUM_OUT(NUM_OUT), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .s_axi_aclk   (s_axi_aclk),
        .reset        (reset),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy),
        .o_frame_count(o_frame_count)
    );

    // Free-running 10-time-unit clock
    initial begin
        s_axi_aclk = 1'b0;
        forever #5 s_axi_aclk = ~s_axi_aclk;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NUM_OUT*DW-1:0] mkRamp(input int base);
        logic [NUM_OUT*DW-1:0] v;
        for (int k = 0; k < NUM_OUT; k++) begin
            v[k*DW +: DW] = DW'(base + k);
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulse i_valid for one clock edge. The task returns at the negedge after the capture.
    task automatic applyStimulus(input logic [NUM_OUT*DW-1:0] vec);
        i_valid = 1'b1;
        i_data  = vec;
        @(negedge s_axi_aclk);
        i_valid = 1'b0;
    endtask

    // Consume one frame, starting at a negedge where beat 0 must already be presented.
    // Optionally inject a new vector on the same edge as the final handshake.
    task automatic expectFrame(input string tag, input logic [NUM_OUT*DW-1:0] vec,
                               input int amax, input bit toggle,
                               input bit inject, input logic [NUM_OUT*DW-1:0] inj_vec);
        int  beat;
        int  cyc;
        bit  rdy;
        logic [DW-1:0] exp_data;
        beat = 0;
        cyc  = 0;
        while (beat < FRAME_LEN && cyc < 60) begin
            rdy = toggle ? ((cyc % 3) == 0) : 1'b1;
            m_axis_tready = rdy;
            if (beat < NUM_OUT) exp_data = vec[beat*DW +: DW];
            else                exp_data = DW'(amax);
            checkOutput({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd1);
            checkOutput({tag, "_tdata"},  32'(m_axis_tdata),  32'(exp_data));
            checkOutput({tag, "_tlast"},  32'(m_axis_tlast),  32'(beat == FRAME_LEN - 1));
            if (inject && rdy && beat == FRAME_LEN - 1) begin
                i_valid = 1'b1;
                i_data  = inj_vec;
            end
            @(negedge s_axi_aclk);
            i_valid = 1'b0;
            if (rdy) beat++;
            cyc++;
        end
        checkOutput({tag, "_beats"}, 32'(beat), 32'(FRAME_LEN));
    endtask

    initial begin
        logic [NUM_OUT*DW-1:0] vec_a;
        logic [NUM_OUT*DW-1:0] vec_b;
        logic [NUM_OUT*DW-1:0] vec_c;
        logic [NUM_OUT*DW-1:0] vec_d;
        logic [NUM_OUT*DW-1:0] vec_e;
        logic [NUM_OUT*DW-1:0] vec_f;
        logic [NUM_OUT*DW-1:0] vec_g;
        logic [NUM_OUT*DW-1:0] vec_h;
        vec_a = mkRamp(0);
        vec_b = mkRamp(16'h100);
        vec_c = mkRamp(16'h200);
        vec_d = mkRamp(16'h300);
        vec_e = mkRamp(16'h500);
        vec_f = mkRamp(16'h600);
        vec_g = mkRamp(16'h700);
        vec_h = mkRamp(16'h800);

        reset         = 1'b1;
        i_valid       = 1'b0;
        i_data        = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge s_axi_aclk);

        // Reset state
        checkOutput("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_tlast",    32'(m_axis_tlast),  32'd0);
        checkOutput("rst_tdata",    32'(m_axis_tdata),  32'd0);
        checkOutput("rst_overflow", 32'(o_overflow),    32'd0);
        checkOutput("rst_busy",     32'(o_busy),        32'd0);
        checkOutput("rst_count",    32'(o_frame_count), 32'd0);
        reset = 1'b0;
        @(negedge s_axi_aclk);

        // Test 1: ramp 0..9, tready held high
        m_axis_tready = 1'b1;
        applyStimulus(vec_a);
        checkOutput("t1_latency_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("t1_busy_buffered",  32'(o_busy),        32'd1);
        @(negedge s_axi_aclk);
        expectFrame("t1", vec_a, 9, 1'b0, 1'b0, '0);
        checkOutput("t1_idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("t1_count",       32'(o_frame_count), 32'd1);
        checkOutput("t1_busy",        32'(o_busy),        32'd0);
        m_axis_tready = 1'b0;

        // Test 2: same ramp with tready pattern 1,0,0 repeating
        applyStimulus(vec_a);
        @(negedge s_axi_aclk);
        expectFrame("t2", vec_a, 9, 1'b1, 1'b0, '0);
        checkOutput("t2_count", 32'(o_frame_count), 32'd2);
        checkOutput("t2_busy",  32'(o_busy),        32'd0);
        m_axis_tready = 1'b0;

        // Test 3: three pulses while stalled. The third is dropped, then two frames run back to back.
        applyStimulus(vec_b);
        @(negedge s_axi_aclk);
        applyStimulus(vec_c);
        @(negedge s_axi_aclk);
        checkOutput("t3_no_overflow_yet", 32'(o_overflow), 32'd0);
        applyStimulus(vec_d);
        checkOutput("t3_overflow", 32'(o_overflow),   32'd1);
        checkOutput("t3_busy",     32'(o_busy),       32'd1);
        checkOutput("t3_hold",     32'(m_axis_tdata), 32'h100);
        expectFrame("t3b", vec_b, 9, 1'b0, 1'b0, '0);
        expectFrame("t3c", vec_c, 9, 1'b0, 1'b0, '0);
        checkOutput("t3_idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("t3_count",       32'(o_frame_count), 32'd4);
        checkOutput("t3_sticky",      32'(o_overflow),    32'd1);
        m_axis_tready = 1'b0;

        // Clear the sticky overflow before the same-edge test
        reset = 1'b1;
        repeat (2) @(negedge s_axi_aclk);
        checkOutput("rst2_overflow", 32'(o_overflow),    32'd0);
        checkOutput("rst2_count",    32'(o_frame_count), 32'd0);
        reset = 1'b0;
        @(negedge s_axi_aclk);

        // Test 4: both slots full, and a new vector arrives on frame D's final handshake
        applyStimulus(vec_d);
        @(negedge s_axi_aclk);
        applyStimulus(vec_e);
        checkOutput("t4_busy", 32'(o_busy), 32'd1);
        expectFrame("t4d", vec_d, 9, 1'b0, 1'b1, vec_f);
        checkOutput("t4_overflow", 32'(o_overflow), 32'd0);
        expectFrame("t4e", vec_e, 9, 1'b0, 1'b0, '0);
        expectFrame("t4f", vec_f, 9, 1'b0, 1'b0, '0);
        checkOutput("t4_count",       32'(o_frame_count), 32'd3);
        checkOutput("t4_overflow_end", 32'(o_overflow),   32'd0);
        checkOutput("t4_idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        m_axis_tready = 1'b0;

        // Test 5: reset while beat 4 is on the bus
        applyStimulus(vec_g);
        @(negedge s_axi_aclk);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t5_pre_tdata", 32'(m_axis_tdata), 32'(16'h700 + i));
            @(negedge s_axi_aclk);
        end
        checkOutput("t5_beat4", 32'(m_axis_tdata), 32'h704);
        reset         = 1'b1;
        m_axis_tready = 1'b0;
        @(negedge s_axi_aclk);
        checkOutput("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("t5_busy",   32'(o_busy),        32'd0);
        checkOutput("t5_count",  32'(o_frame_count), 32'd0);
        checkOutput("t5_tlast",  32'(m_axis_tlast),  32'd0);
        reset = 1'b0;
        @(negedge s_axi_aclk);
        checkOutput("t5_stays_idle", 32'(m_axis_tvalid), 32'd0);
        m_axis_tready = 1'b1;
        applyStimulus(vec_h);
        @(negedge s_axi_aclk);
        expectFrame("t5h", vec_h, 9, 1'b0, 1'b0, '0);
        checkOutput("t5_count_after", 32'(o_frame_count), 32'd1);
        m_axis_tready = 1'b0;

`ifdef ARGMAX_EN
        // Test 6: argmax beat, including a tie and an all-negative vector
        begin
            int t6 [NUM_OUT];
            logic [NUM_OUT*DW-1:0] vec_m;
            logic [NUM_OUT*DW-1:0] vec_n;
            t6 = '{-5, 3, 7, 7, -1, 0, 2, 1, -8, 6};
            for (int k = 0; k < NUM_OUT; k++) begin
                vec_m[k*DW +: DW] = DW'(t6[k]);
                vec_n[k*DW +: DW] = 16'hFFFF;
            end
            m_axis_tready = 1'b1;
            applyStimulus(vec_m);
            @(negedge s_axi_aclk);
            expectFrame("t6m", vec_m, 2, 1'b0, 1'b0, '0);
            applyStimulus(vec_n);
            @(negedge s_axi_aclk);
            expectFrame("t6n", vec_n, 0, 1'b0, 1'b0, '0);
            checkOutput("t6_count", 32'(o_frame_count), 32'd3);
            m_axis_tready = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
